// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one request at a time to a variable-latency imem and buffers
// the returned word for IF/ID. Optional perf counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_plus_4_out,
   output logic        if_id_enable,
   output logic        fetch_valid
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] fetched_count,
   output logic [31:0] squashed_count
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        drop_q, drop_d;
   logic        req_q;
   logic        consume_s;
   logic        squash_s;

   // Next-state: redirect overrides everything; drop marks an in-flight request whose data must be discarded.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_instr_d   = buf_instr_q;
      buf_pc4_d     = buf_pc4_q;
      fetch_valid_d = fetch_valid_q;
      drop_d        = drop_q;
      consume_s     = 1'b0;
      squash_s      = 1'b0;
      if (redirect_valid) begin
         pc_d          = redirect_target;
         fetch_valid_d = 1'b0;
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  drop_d   = 1'b1;
                  state_d  = S_WAIT;
                  squash_s = 1'b1;
               end else begin
                  state_d  = S_FETCH;
               end
            end
            S_WAIT: begin
               squash_s = ~drop_q;
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_HOLD: begin
               squash_s = fetch_valid_q;
               state_d  = S_FETCH;
            end
            default: begin
               drop_d  = 1'b0;
               state_d = S_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_WAIT: begin
               if (imem_rvalid && drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_FETCH;
               end else if (imem_rvalid) begin
                  buf_instr_d   = imem_rdata;
                  buf_pc4_d     = pc_q + 32'd4;
                  pc_d          = pc_q + 32'd4;
                  fetch_valid_d = 1'b1;
                  state_d       = S_HOLD;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_HOLD: begin
               if (fetch_valid_q && !stall_in) begin
                  consume_s     = 1'b1;
                  fetch_valid_d = 1'b0;
                  state_d       = S_FETCH;
               end else begin
                  state_d = S_HOLD;
               end
            end
            default: begin
               drop_d  = 1'b0;
               state_d = S_FETCH;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         buf_instr_q   <= NOP_WORD;
         buf_pc4_q     <= 32'h0000_0000;
         fetch_valid_q <= 1'b0;
         drop_q        <= 1'b0;
         req_q         <= 1'b1;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         buf_instr_q   <= buf_instr_d;
         buf_pc4_q     <= buf_pc4_d;
         fetch_valid_q <= fetch_valid_d;
         drop_q        <= drop_d;
         req_q         <= (state_d == S_FETCH);
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetched_q;
   logic [31:0] squashed_q;

   // Performance counters; free-running and wrapping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetched_q  <= 32'h0000_0000;
         squashed_q <= 32'h0000_0000;
      end else begin
         fetched_q  <= fetched_q + {31'h0000_0000, consume_s};
         squashed_q <= squashed_q + {31'h0000_0000, squash_s};
      end
   end

   assign fetched_count  = fetched_q;
   assign squashed_count = squashed_q;
`endif

   // The instruction is the only output that sees the redirect combinationally, so a squash never reaches IF/ID.
   assign instruction_out = (fetch_valid_q && !redirect_valid) ? buf_instr_q : NOP_WORD;
   assign pc_plus_4_out   = buf_pc4_q;
   assign if_id_enable    = ~stall_in;
   assign fetch_valid     = fetch_valid_q;
   assign imem_req        = req_q;
   assign imem_addr       = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: a random-latency memory plus a program-order
// reference model that predicts every word, PC+4, request and buffer-valid state IF/ID should see.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_in;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_out;
   logic [31:0] pc_plus_4_out;
   logic        if_id_enable;
   logic        fetch_valid;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] fetched_count;
   logic [31:0] squashed_count;
`endif

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .stall_in        (stall_in),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instruction_out (instruction_out),
      .pc_plus_4_out   (pc_plus_4_out),
      .if_id_enable    (if_id_enable),
      .fetch_valid     (fetch_valid)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .fetched_count   (fetched_count),
      .squashed_count  (squashed_count)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Reference model: program order, buffer occupancy and memory-transaction bookkeeping.
   logic [31:0] exp_pc;
   logic [31:0] m_addr;
   logic [31:0] acc_addr;
   bit          m_fv, m_pending, m_killed, stray_next;
   bit          resp, accept, consume, exp_req;
   int          m_cnt;
   int          idle;
   int          n_consumed;
   logic [31:0] exp_fetched, exp_squashed;

   initial begin
      reset = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      exp_pc = RESET_PC; m_fv = 1'b0; m_pending = 1'b0; m_killed = 1'b0; stray_next = 1'b0;
      m_cnt = 0; idle = 0; n_consumed = 0; exp_fetched = 32'h0; exp_squashed = 32'h0;
      m_addr = 32'h0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         reset           = !(m_pending && ($urandom_range(0, 149) == 0));
         stall_in        = ($urandom_range(0, 9) < 3);
         redirect_valid  = ($urandom_range(0, 19) == 0);
         redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         imem_ready      = ($urandom_range(0, 9) < 7);
         resp            = m_pending && (m_cnt == 0);
         if (resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
         end else if (stray_next || (!m_pending && ($urandom_range(0, 9) == 0))) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom();
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
         end
         stray_next = 1'b0;
         #1;

         exp_req = !m_pending && !m_fv;
         check_eq("if_id_enable", 32'(if_id_enable), 32'(!stall_in));
         check_eq("fetch_valid", 32'(fetch_valid), 32'(m_fv));
         check_eq("imem_req", 32'(imem_req), 32'(exp_req));
         if (imem_req) check_eq("imem_addr", imem_addr, exp_pc);
         check_eq("instruction_out", instruction_out,
                  (m_fv && !redirect_valid) ? mem_word(exp_pc) : NOP);
         if (m_fv) check_eq("pc_plus_4_out", pc_plus_4_out, exp_pc + 32'd4);
`ifdef FETCH_PERF_COUNTERS_EN
         check_eq("fetched_count", fetched_count, exp_fetched);
         check_eq("squashed_count", squashed_count, exp_squashed);
`endif
         accept   = imem_req && imem_ready;
         acc_addr = imem_addr;
         consume  = m_fv && !stall_in && !redirect_valid && reset;
         if (consume) begin
            idle = 0;
            n_consumed++;
         end else begin
            idle++;
         end
         if (idle > 400) begin
            check_eq("liveness_idle_cycles", 32'(idle), 32'd0);
            break;
         end

         @(posedge clk);
         if (!reset) begin
            exp_pc = RESET_PC; m_fv = 1'b0; stray_next = m_pending;
            m_pending = 1'b0; m_killed = 1'b0;
            exp_fetched = 32'h0; exp_squashed = 32'h0;
         end else begin
            if (redirect_valid) begin
               exp_squashed = exp_squashed + 32'(m_fv) + 32'(accept) + 32'(m_pending && !m_killed);
               exp_pc = redirect_target;
               m_fv   = 1'b0;
               if (m_pending && !resp) m_killed = 1'b1;
            end else if (consume) begin
               exp_fetched = exp_fetched + 32'd1;
               exp_pc      = exp_pc + 32'd4;
               m_fv        = 1'b0;
            end
            if (m_pending) begin
               if (resp) begin
                  m_pending = 1'b0;
                  if (!m_killed && !redirect_valid) m_fv = 1'b1;
               end else begin
                  m_cnt--;
               end
            end
            if (accept) begin
               m_pending = 1'b1;
               m_killed  = redirect_valid;
               m_cnt     = $urandom_range(0, 3);
               m_addr    = acc_addr;
            end
         end
      end

      check_eq("enough_consumed", 32'(n_consumed > 100), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage feeding the IF/ID pipeline register: owns the PC, issues one request at a time to a variable-latency instruction memory, and buffers the returned word. It presents `instruction_out` / `pc_plus_4_out` / `if_id_enable` to IF/ID, holds them under hazard stalls, and squashes wrong-path fetches on branch/jump redirects by substituting NOP bubbles.

## Interface
Parameters:
- `RESET_PC`, 32'h0040_0000, PC loaded on reset.
- `NOP_WORD`, 32'h0000_0000, word emitted when no valid instruction is available.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `stall_in`  in  1  hazard unit holds IF/ID (1 = hold).
- `redirect_valid`  in  1  taken branch/jump resolved this cycle.
- `redirect_target`  in  32  new PC; word-aligned.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address (= PC).
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instruction_out`  out  32  to IF/ID `instruction_in`.
- `pc_plus_4_out`  out  32  to IF/ID `pc_plus_4_in`.
- `if_id_enable`  out  1  to IF/ID `enable`; equals `!stall_in`.
- `fetch_valid`  out  1  buffer holds a valid, unsquashed instruction.

## Operation
- Registers: `pc`, `buf_instr`, `buf_pc4`, `fetch_valid`, `drop`, 2-bit `state`.
- States: FETCH (`imem_req`=1, `imem_addr`=`pc`), WAIT (request accepted, awaiting `imem_rvalid`), HOLD (buffer full, waiting for consumption).
- FETCH: on `imem_ready`, go WAIT. No `imem_ready`: stay, hold address stable.
- WAIT: on `imem_rvalid` with `drop`=0: `buf_instr`<=`imem_rdata`, `buf_pc4`<=`pc`+4, `pc`<=`pc`+4, `fetch_valid`<=1, go HOLD. With `drop`=1: discard, clear `drop`, go FETCH.
- HOLD: consumed when `fetch_valid` & !`stall_in` & !`redirect_valid`; then `fetch_valid`<=0, go FETCH. Otherwise hold.
- Outputs: `instruction_out` = `buf_instr` when `fetch_valid` & !`redirect_valid`, else `NOP_WORD`; `pc_plus_4_out` = `buf_pc4` (don't-care on bubbles); `if_id_enable` = !`stall_in`.
- Redirect (highest priority, any state): `pc`<=`redirect_target`, `fetch_valid`<=0, current output forced to NOP. From WAIT without same-cycle `imem_rvalid`: `drop`<=1, stay WAIT. From WAIT with same-cycle `imem_rvalid`: data discarded, go FETCH. From FETCH with same-cycle `imem_ready`: `drop`<=1, go WAIT. Otherwise go FETCH.
- `redirect_valid` & `stall_in` together: redirect still applies; `if_id_enable`=0.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Single outstanding request; `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset (`reset`=0 at posedge): `pc`=`RESET_PC`, state FETCH, `fetch_valid`=0, `drop`=0, `buf_instr`=`NOP_WORD`, `buf_pc4`=0. Hence `imem_req`=1, `imem_addr`=`RESET_PC`, `instruction_out`=`NOP_WORD`, `if_id_enable`=!`stall_in`. Reset mid-WAIT abandons the request; a later stray `imem_rvalid` is ignored because state is FETCH.
- Latency: request accepted at edge N, `imem_rvalid` at N+k (k≥1), `fetch_valid`=1 after edge N+k, IF/ID loads at the next edge if not stalled.
- Peak throughput with k=1: one instruction per 3 cycles.
- `instruction_out` depends combinationally on `redirect_valid`; all other outputs are registered or come from `stall_in`.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined: adds outputs `fetched_count` [31:0] (increments per consumed instruction) and `squashed_count` [31:0] (increments per valid buffer or in-flight request killed by redirect). Both reset to 0 and wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, memory k=1, no stall, sequential words A,B,C: IF/ID receives A/pc4 0x00400004, B/0x00400008, C/0x0040000C, 2 NOP cycles between each.
- `stall_in`=1 for 4 cycles while HOLD with word A: `instruction_out`=A throughout, `if_id_enable`=0, no new `imem_req`; A consumed first cycle after release.
- Redirect to 0x00400100 while WAIT (k=3): late response discarded, next `imem_addr`=0x00400100, no wrong-path word reaches IF/ID; `squashed_count`=1 if enabled.
- Redirect in the same cycle as HOLD consumption: `instruction_out`=NOP, buffer cleared, next fetch at target.
- `reset`=0 asserted during WAIT, stray `imem_rvalid` next cycle: ignored, `imem_addr`=0x00400000, `fetch_valid`=0.
- PC 0xFFFFFFFC fetched: `pc_plus_4_out`=0, next `imem_addr`=0.
